// File: rtl/ov7670_cap_pkg.sv
// Shared encodings for the OV7670 capture path: output formats, pixel widths,
// capture FSM states and colour-bar constants.
package ov7670_cap_pkg;

    localparam int unsigned FmtRgb444 = 0;
    localparam int unsigned FmtRgb565 = 1;
    localparam int unsigned FmtRgb332 = 2;

    function automatic int unsigned pix_w(input int unsigned fmt);
        case (fmt)
            FmtRgb565: return 16;
            FmtRgb332: return 8;
            default:   return 12;
        endcase
    endfunction

    typedef enum logic [1:0] {
        StIdle,
        StWaitVs,
        StWaitFr,
        StActive
    } cap_state_e;

    localparam int unsigned NumBars = 8;
    localparam logic [4:0]  BarR    = 5'h1f;
    localparam logic [5:0]  BarG    = 6'h3f;
    localparam logic [4:0]  BarB    = 5'h1f;

endpackage

// File: rtl/ov7670_px_convert.sv
// Combinational RGB565 to OUT_FMT pixel converter.
module ov7670_px_convert
    import ov7670_cap_pkg::*;
#(
    parameter int unsigned  OUT_FMT = FmtRgb444,
    localparam int unsigned PIX_W   = pix_w(OUT_FMT)
) (
    input  logic [15:0]      rgb565,
    output logic [PIX_W-1:0] pix
);

    // rgb565 layout: R = [15:11], G = [10:5], B = [4:0]
    if (OUT_FMT == FmtRgb565) begin : g_rgb565
        assign pix = rgb565;
    end else if (OUT_FMT == FmtRgb332) begin : g_rgb332
        logic unused_bits;
        assign pix         = {rgb565[15:13], rgb565[10:8], rgb565[4:3]};
        assign unused_bits = ^{rgb565[12:11], rgb565[7:5], rgb565[2:0]};
    end else begin : g_rgb444
        logic unused_bits;
        assign pix         = {rgb565[15:12], rgb565[10:7], rgb565[4:1]};
        assign unused_bits = ^{rgb565[11], rgb565[6:5], rgb565[0]};
    end

endmodule

// File: rtl/ov7670_capture_px.sv
// OV7670 capture front end: byte assembly, format conversion, decimation and frame-buffer
// addressing. Define OV7670_TEST_PATTERN_EN to add the test_pat colour-bar input.
module ov7670_capture_px
    import ov7670_cap_pkg::*;
#(
    parameter int unsigned  H_ACTIVE = 640,
    parameter int unsigned  V_ACTIVE = 480,
    parameter int unsigned  DECIM    = 1,
    parameter int unsigned  OUT_FMT  = FmtRgb444,
    parameter int unsigned  ADDR_W   = 19,
    localparam int unsigned PIX_W    = pix_w(OUT_FMT)
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              cap_en,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d,
`ifdef OV7670_TEST_PATTERN_EN
    input  logic              test_pat,
`endif
    output logic [ADDR_W-1:0] addr,
    output logic [PIX_W-1:0]  dout,
    output logic              we,
    output logic              frame_done,
    output logic              overflow,
    output logic              busy
);

    localparam int unsigned       FRAME_WORDS = (H_ACTIVE / DECIM) * (V_ACTIVE / DECIM);
    localparam logic [ADDR_W-1:0] LastAddr    = ADDR_W'(FRAME_WORDS - 1);
    localparam logic [15:0]       DecMask     = 16'(DECIM - 1);

    cap_state_e        state_q, state_d;
    logic              vsync_q, href_q, phase_q, full_q;
    logic [7:0]        hi_q;
    logic [15:0]       x_q, y_q;
    logic [ADDR_W-1:0] addr_q;
    logic [PIX_W-1:0]  dout_q;
    logic              we_q, frame_done_q, overflow_q;

    logic              vs_rise, vs_fall, href_fall, active, px_done, keep, start;
    logic [15:0]       px_src;
    logic [PIX_W-1:0]  px_conv;

    assign vs_rise   = vsync & ~vsync_q;
    assign vs_fall   = ~vsync & vsync_q;
    assign href_fall = ~href & href_q;
    assign active    = (state_q == StActive);
    assign px_done   = active & href & phase_q;
    assign keep      = px_done && ((x_q & DecMask) == '0) && ((y_q & DecMask) == '0);
    assign start     = (state_q == StWaitFr) & vs_fall & cap_en;

`ifdef OV7670_TEST_PATTERN_EN
    logic [2:0] bar;
    assign bar    = 3'((32'(x_q) * NumBars) / H_ACTIVE);
    assign px_src = test_pat ? {bar[2] ? BarR : 5'h0, bar[1] ? BarG : 6'h0, bar[0] ? BarB : 5'h0}
                             : {hi_q, d};
`else
    assign px_src = {hi_q, d};
`endif

    ov7670_px_convert #(
        .OUT_FMT(OUT_FMT)
    ) u_convert (
        .rgb565(px_src),
        .pix   (px_conv)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (cap_en) state_d = StWaitVs;
            StWaitVs: if (vsync) state_d = StWaitFr;
            StWaitFr: if (vs_fall) state_d = cap_en ? StActive : StIdle;
            StActive: if (vs_rise) state_d = StWaitFr;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            phase_q      <= 1'b0;
            hi_q         <= '0;
            x_q          <= '0;
            y_q          <= '0;
            addr_q       <= '0;
            full_q       <= 1'b0;
            dout_q       <= '0;
            we_q         <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            vsync_q      <= vsync;
            href_q       <= href;
            frame_done_q <= active & vs_rise;
            we_q         <= 1'b0;
            phase_q      <= active & href & ~phase_q;
            if (active && href && !phase_q) begin
                hi_q <= d;
            end
            if (start) begin
                x_q        <= '0;
                y_q        <= '0;
                addr_q     <= '0;
                full_q     <= 1'b0;
                overflow_q <= 1'b0;
            end else if (active) begin
                if (href_fall) begin
                    x_q <= '0;
                    y_q <= y_q + 16'd1;
                end else if (px_done) begin
                    x_q <= x_q + 16'd1;
                end
                // Advance after the write cycle; the last address is held and marked full.
                if (we_q) begin
                    if (addr_q == LastAddr) begin
                        full_q <= 1'b1;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
                if (keep) begin
                    if (full_q) begin
                        overflow_q <= 1'b1;
                    end else begin
                        we_q   <= 1'b1;
                        dout_q <= px_conv;
                    end
                end
            end
        end
    end

    assign addr       = addr_q;
    assign dout       = dout_q;
    assign we         = we_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
    assign busy       = active;

endmodule

// File: tb/tb_ov7670_capture_px.sv
// Scoreboard bench for ov7670_capture_px: three instances (RGB444, DECIM=2 RGB565, RGB332)
// driven one at a time; expected writes are queued and checked by a monitor.
`timescale 1ns/1ps
module tb_ov7670_capture_px;

    localparam int NU = 3;

    logic pclk = 1'b0;
    logic rst_n = 1'b0;
    always #5 pclk = ~pclk;

    logic       vsync_s[NU];
    logic       href_s[NU];
    logic       cap_en_s[NU];
    logic [7:0] d_s[NU];
`ifdef OV7670_TEST_PATTERN_EN
    logic       test_pat_s[NU];
`endif

    logic [4:0]  a_addr;
    logic [11:0] a_dout;
    logic [2:0]  b_addr;
    logic [15:0] b_dout;
    logic [4:0]  c_addr;
    logic [7:0]  c_dout;
    logic        m_we[NU], m_fd[NU], m_ovf[NU], m_busy[NU];
    logic [15:0] m_addr[NU], m_dout[NU];

    ov7670_capture_px #(.H_ACTIVE(8), .V_ACTIVE(4), .DECIM(1), .OUT_FMT(0), .ADDR_W(5)) dut_a (
        .pclk(pclk), .rst_n(rst_n), .cap_en(cap_en_s[0]), .vsync(vsync_s[0]),
        .href(href_s[0]), .d(d_s[0]),
`ifdef OV7670_TEST_PATTERN_EN
        .test_pat(test_pat_s[0]),
`endif
        .addr(a_addr), .dout(a_dout), .we(m_we[0]), .frame_done(m_fd[0]),
        .overflow(m_ovf[0]), .busy(m_busy[0])
    );

    ov7670_capture_px #(.H_ACTIVE(8), .V_ACTIVE(4), .DECIM(2), .OUT_FMT(1), .ADDR_W(3)) dut_b (
        .pclk(pclk), .rst_n(rst_n), .cap_en(cap_en_s[1]), .vsync(vsync_s[1]),
        .href(href_s[1]), .d(d_s[1]),
`ifdef OV7670_TEST_PATTERN_EN
        .test_pat(test_pat_s[1]),
`endif
        .addr(b_addr), .dout(b_dout), .we(m_we[1]), .frame_done(m_fd[1]),
        .overflow(m_ovf[1]), .busy(m_busy[1])
    );

    ov7670_capture_px #(.H_ACTIVE(8), .V_ACTIVE(4), .DECIM(1), .OUT_FMT(2), .ADDR_W(5)) dut_c (
        .pclk(pclk), .rst_n(rst_n), .cap_en(cap_en_s[2]), .vsync(vsync_s[2]),
        .href(href_s[2]), .d(d_s[2]),
`ifdef OV7670_TEST_PATTERN_EN
        .test_pat(test_pat_s[2]),
`endif
        .addr(c_addr), .dout(c_dout), .we(m_we[2]), .frame_done(m_fd[2]),
        .overflow(m_ovf[2]), .busy(m_busy[2])
    );

    assign m_addr[0] = 16'(a_addr);
    assign m_addr[1] = 16'(b_addr);
    assign m_addr[2] = 16'(c_addr);
    assign m_dout[0] = 16'(a_dout);
    assign m_dout[1] = b_dout;
    assign m_dout[2] = 16'(c_dout);

    typedef struct {
        int unit;
        int addr;
        int dout;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   fd_cnt[NU];

    // Monitor: every write strobe pops the oldest expected write.
    always @(negedge pclk) begin
        exp_t e;
        if (rst_n) begin
            for (int u = 0; u < NU; u++) begin
                if (m_fd[u]) fd_cnt[u]++;
                if (m_we[u]) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_write unit=%0d: got addr=%0d dout=%h, required no write",
                                 u, m_addr[u], m_dout[u]);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.unit != u || e.addr != int'(m_addr[u]) || e.dout != int'(m_dout[u])) begin
                            n_bad++;
                            $display("FAIL write unit=%0d: got addr=%0d dout=%h, required unit=%0d addr=%0d dout=%h",
                                     u, m_addr[u], m_dout[u], e.unit, e.addr, e.dout);
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic expect_wr(input int u, input int a, input int dv);
        exp_t e;
        e.unit = u;
        e.addr = a;
        e.dout = dv;
        exp_q.push_back(e);
    endtask

    task automatic expect_run(input int u, input int a0, input int n, input int dv);
        for (int i = 0; i < n; i++) expect_wr(u, a0 + i, dv);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic frame_start(input int u);
        vsync_s[u] = 1'b1;
        tick(3);
        vsync_s[u] = 1'b0;
        tick(2);
    endtask

    task automatic frame_end(input int u);
        vsync_s[u] = 1'b1;
        tick(3);
    endtask

    // Even byte slots carry hi + pixel*step, odd slots carry lo.
    task automatic send_line(input int u, input int nbytes, input int hi, input int lo,
                             input int step);
        for (int i = 0; i < nbytes; i++) begin
            href_s[u] = 1'b1;
            d_s[u]    = (i % 2 == 0) ? 8'(hi + (i / 2) * step) : 8'(lo);
            tick(1);
        end
        href_s[u] = 1'b0;
        d_s[u]    = 8'h00;
        tick(3);
    endtask

    int fa;
    int b_exp[8] = '{'h00A5, 'h02A5, 'h04A5, 'h06A5, 'h20A5, 'h22A5, 'h24A5, 'h26A5};
`ifdef OV7670_TEST_PATTERN_EN
    int bar_exp[8] = '{'h000, 'h00F, 'h0F0, 'h0FF, 'hF00, 'hF0F, 'hFF0, 'hFFF};
`endif

    initial begin
        fa = 0;
        for (int u = 0; u < NU; u++) begin
            vsync_s[u]  = 1'b0;
            href_s[u]   = 1'b0;
            cap_en_s[u] = 1'b0;
            d_s[u]      = 8'h00;
            fd_cnt[u]   = 0;
`ifdef OV7670_TEST_PATTERN_EN
            test_pat_s[u] = 1'b0;
`endif
        end
        tick(2);
        check("rst_addr", int'(m_addr[0]), 0);
        check("rst_dout", int'(m_dout[0]), 0);
        check("rst_we", int'(m_we[0]), 0);
        check("rst_frame_done", int'(m_fd[0]), 0);
        check("rst_overflow", int'(m_ovf[0]), 0);
        check("rst_busy", int'(m_busy[0]), 0);
        rst_n = 1'b1;
        tick(2);

        // Two plain frames of pixel 0xF81F -> RGB444 0xF0F.
        cap_en_s[0] = 1'b1;
        tick(2);
        check("busy_wait_vs", int'(m_busy[0]), 0);
        for (int f = 0; f < 2; f++) begin
            expect_run(0, 0, 32, 'hF0F);
            frame_start(0);
            check("busy_active", int'(m_busy[0]), 1);
            for (int y = 0; y < 4; y++) send_line(0, 16, 'hF8, 'h1F, 0);
            frame_end(0);
            fa++;
            check("frame_done_count", fd_cnt[0], fa);
            check("overflow_clean", int'(m_ovf[0]), 0);
            check("busy_after_frame", int'(m_busy[0]), 0);
        end

        // 10-pixel lines: 32 writes of 0x1234 -> 0x14A, then overflow.
        expect_run(0, 0, 32, 'h14A);
        frame_start(0);
        for (int y = 0; y < 4; y++) send_line(0, 20, 'h12, 'h34, 0);
        frame_end(0);
        fa++;
        check("overflow_set", int'(m_ovf[0]), 1);
        check("addr_saturated", int'(m_addr[0]), 31);
        check("frame_done_overflow", fd_cnt[0], fa);

        // Odd trailing byte, then cap_en dropped mid-frame.
        expect_wr(0, 0, 'hF0F);
        expect_run(0, 1, 24, 'h14A);
        frame_start(0);
        check("overflow_cleared", int'(m_ovf[0]), 0);
        send_line(0, 3, 'hF8, 'h1F, 0);
        send_line(0, 16, 'h12, 'h34, 0);
        cap_en_s[0] = 1'b0;
        send_line(0, 16, 'h12, 'h34, 0);
        send_line(0, 16, 'h12, 'h34, 0);
        frame_end(0);
        fa++;
        check("frame_done_cap_off", fd_cnt[0], fa);

        // Now idle: a whole frame produces nothing.
        frame_start(0);
        check("busy_idle", int'(m_busy[0]), 0);
        send_line(0, 16, 'hF8, 'h1F, 0);
        send_line(0, 16, 'hF8, 'h1F, 0);
        frame_end(0);
        check("frame_done_idle", fd_cnt[0], fa);

        // Enable mid-frame with vsync already low: wait for a full vsync cycle.
        vsync_s[0] = 1'b0;
        tick(2);
        cap_en_s[0] = 1'b1;
        tick(1);
        send_line(0, 16, 'hF8, 'h1F, 0);
        send_line(0, 16, 'hF8, 'h1F, 0);
        check("busy_mid_frame_enable", int'(m_busy[0]), 0);
        expect_run(0, 0, 32, 'hF0F);
        frame_start(0);
        for (int y = 0; y < 4; y++) send_line(0, 16, 'hF8, 'h1F, 0);
        frame_end(0);
        fa++;
        check("frame_done_resync", fd_cnt[0], fa);

`ifdef OV7670_TEST_PATTERN_EN
        test_pat_s[0] = 1'b1;
        for (int i = 0; i < 8; i++) expect_wr(0, i, bar_exp[i]);
        frame_start(0);
        send_line(0, 16, 'h12, 'h34, 0);
        frame_end(0);
        fa++;
        test_pat_s[0] = 1'b0;
        check("frame_done_test_pat", fd_cnt[0], fa);
`endif

        // Asynchronous reset: once between frames, once while active.
        rst_n = 1'b0;
        #2;
        check("async_rst_addr", int'(m_addr[0]), 0);
        tick(1);
        rst_n = 1'b1;
        tick(2);
        frame_start(0);
        check("busy_before_rst", int'(m_busy[0]), 1);
        rst_n = 1'b0;
        #2;
        check("async_rst_busy", int'(m_busy[0]), 0);
        check("async_rst_we", int'(m_we[0]), 0);
        tick(1);
        rst_n = 1'b1;
        tick(2);

        // DECIM=2, RGB565 passthrough: even pixels of lines 0 and 2.
        cap_en_s[1] = 1'b1;
        tick(2);
        for (int i = 0; i < 8; i++) expect_wr(1, i, b_exp[i]);
        frame_start(1);
        for (int y = 0; y < 4; y++) send_line(1, 16, y * 16, 'hA5, 1);
        frame_end(1);
        check("frame_done_decim", fd_cnt[1], 1);

        // RGB332: 0xFFE0 -> 0xFC, 0x1234 -> 0x0A.
        cap_en_s[2] = 1'b1;
        tick(2);
        expect_run(2, 0, 2, 'hFC);
        expect_run(2, 2, 2, 'h0A);
        frame_start(2);
        send_line(2, 4, 'hFF, 'hE0, 0);
        send_line(2, 4, 'h12, 'h34, 0);
        frame_end(2);
        check("frame_done_rgb332", fd_cnt[2], 1);

        tick(5);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
